coord_feeder: RTL

Upstream coordinate source for the pen-plotter motor controller. Buffers drawing points (9-bit X/Y grid cell plus pen-down flag) from the path generator in a FIFO. Answers each single-cycle coordinate request from the motor controller with one point and a one-cycle done strobe. After the point flagged last has been delivered, it answers every further request with the 511/511 end-of-drawing sentinel.

---
 rtl/coord_feeder_if.sv | 33 +++
 rtl/coord_feeder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/coord_feeder_if.sv
// Bus between path generator / motor controller and coord_feeder.
// Master drives writes and requests; slave returns points, status and flags.
interface coord_feeder_if #(
  parameter int AW = 6
);
  logic       i_wr_valid;
  logic [8:0] i_wr_x;
  logic [8:0] i_wr_y;
  logic       i_wr_down;
  logic       i_wr_last;
  logic       o_wr_ready;
  logic       i_request;
  logic [8:0] o_coord_x;
  logic [8:0] o_coord_y;
  logic       o_down;
  logic       o_done;
  logic [AW:0] o_count;
  logic       o_overflow;
  logic       o_reject;
  logic [1:0] o_state;

  modport master (
    output i_wr_valid, i_wr_x, i_wr_y, i_wr_down, i_wr_last, i_request,
    input  o_wr_ready, o_coord_x, o_coord_y, o_down, o_done, o_count,
           o_overflow, o_reject, o_state
  );

  modport slave (
    input  i_wr_valid, i_wr_x, i_wr_y, i_wr_down, i_wr_last, i_request,
    output o_wr_ready, o_coord_x, o_coord_y, o_down, o_done, o_count,
           o_overflow, o_reject, o_state
  );
endinterface

// File: rtl/coord_feeder.sv
// Point FIFO plus request FSM: one point per request, o_done two cycles after the request.
// Full or sentinel writes are dropped (sticky flags); after the last point, requests get 511/511.
module coord_feeder #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic          i_clock,
  input logic          i_rst,
  coord_feeder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_END     = 2'd3
  } state_t;

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          wr_ready_q;
  logic          overflow_q;
  logic          reject_q;
  logic          done_q;
  logic [8:0]    x_q;
  logic [8:0]    y_q;
  logic          down_q;
  logic          last_q;
  logic          end_pend;
  state_t        state;

  logic          is_sentinel;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [19:0]   head;

  assign is_sentinel = (bus.i_wr_x == 9'h1FF) && (bus.i_wr_y == 9'h1FF);
  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign push        = bus.i_wr_valid && !full && !is_sentinel;
  // Pop only from the registered occupancy, so a fresh write is visible a cycle later.
  assign pop         = (state == S_FETCH) && !empty;
  assign head        = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + (AW+1)'(1);
    end else if (pop && !push) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr] <= {bus.i_wr_last, bus.i_wr_down, bus.i_wr_y, bus.i_wr_x};
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_ready_q <= 1'b1;
      overflow_q <= 1'b0;
      reject_q   <= 1'b0;
      done_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      down_q     <= 1'b0;
      last_q     <= 1'b0;
      end_pend   <= 1'b0;
      state      <= S_IDLE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count      <= count_nxt;
      wr_ready_q <= (count_nxt != (AW+1)'(DEPTH));

      // A sentinel write counts as a reject, never as an overflow.
      if (bus.i_wr_valid && is_sentinel) begin
        reject_q <= 1'b1;
      end else if (bus.i_wr_valid && full) begin
        overflow_q <= 1'b1;
      end

      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_request) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!empty) begin
            done_q <= 1'b1;
            x_q    <= head[8:0];
            y_q    <= head[17:9];
            down_q <= head[18];
            last_q <= head[19];
            state  <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          state <= last_q ? S_END : S_IDLE;
        end
        S_END: begin
          // end_pend supplies the same two-cycle response as the FETCH path.
          if (end_pend) begin
            done_q   <= 1'b1;
            x_q      <= 9'h1FF;
            y_q      <= 9'h1FF;
            down_q   <= 1'b0;
            end_pend <= 1'b0;
          end else if (bus.i_request) begin
            end_pend <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_wr_ready = wr_ready_q;
  assign bus.o_coord_x  = x_q;
  assign bus.o_coord_y  = y_q;
  assign bus.o_down     = down_q;
  assign bus.o_done     = done_q;
  assign bus.o_count    = count;
  assign bus.o_overflow = overflow_q;
  assign bus.o_reject   = reject_q;
  assign bus.o_state    = state;

endmodule
